// File: rtl/udc_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
// Optional feature macro: UDC_STEP_EN (variable step size).
package udc_pkg;

  typedef enum logic {
    UDC_WRAP,
    UDC_SAT
  } udc_mode_t;

  typedef enum logic [1:0] {
    UDC_HOLD,
    UDC_UP,
    UDC_DOWN
  } udc_dir_t;

  function automatic int clamp(
    input int v,
    input int lo,
    input int hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/udc_next_calc.sv
// Next-count arithmetic for the up/down counter.
// Works in WIDTH+2 bits so carry and borrow are never lost.
module udc_next_calc
  import udc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 15
) (
  input  logic [WIDTH-1:0] count,
  input  udc_dir_t         dir,
  input  logic [WIDTH:0]   s,
  input  udc_mode_t        mode,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_nxt,
  output logic             unf_nxt
);

  localparam int RW = WIDTH + 2;
  localparam logic [RW-1:0] MAX_W = RW'(MAX_VAL);
  localparam logic [RW-1:0] MIN_W = RW'(MIN_VAL);
  localparam logic [RW-1:0] RNG_W =
    RW'(MAX_VAL - MIN_VAL + 1);

  logic [RW-1:0] cnt_w;
  logic [RW-1:0] s_w;
  logic [RW-1:0] up_w;
  logic [RW-1:0] dn_w;
  logic [RW-1:0] up_wrap;
  logic [RW-1:0] dn_wrap;

  assign cnt_w   = RW'(count);
  assign s_w     = RW'(s);
  assign up_w    = cnt_w + s_w;
  assign dn_w    = cnt_w - s_w;
  assign up_wrap = up_w - RNG_W;
  assign dn_wrap = cnt_w + RNG_W - s_w;

  // Step in the requested direction, wrapping or saturating past a bound
  always_comb begin
    next_count = count;
    ovf_nxt    = 1'b0;
    unf_nxt    = 1'b0;
    case (dir)
      UDC_UP: begin
        if (up_w > MAX_W) begin
          ovf_nxt    = 1'b1;
          next_count = (mode == UDC_SAT) ?
            WIDTH'(MAX_VAL) : WIDTH'(up_wrap);
        end else begin
          next_count = WIDTH'(up_w);
        end
      end
      UDC_DOWN: begin
        if (cnt_w < MIN_W + s_w) begin
          unf_nxt    = 1'b1;
          next_count = (mode == UDC_SAT) ?
            WIDTH'(MIN_VAL) : WIDTH'(dn_wrap);
        end else begin
          next_count = WIDTH'(dn_w);
        end
      end
      default: begin
        next_count = count;
      end
    endcase
  end

endmodule

// File: rtl/up_down_counter_param.sv
// Bounded up/down counter with load, wrap/saturate and ovf/unf pulses.
// Define UDC_STEP_EN to add the step port (otherwise unit step).
module up_down_counter_param
  import udc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 15,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
`ifdef UDC_STEP_EN
  input  logic [WIDTH-1:0] step,
`endif
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf
);

  localparam int SW = WIDTH + 1;
  localparam logic [SW-1:0] RNG_S =
    SW'(MAX_VAL - MIN_VAL + 1);

  udc_dir_t         dir;
  udc_mode_t        mode;
  logic [SW-1:0]    s_eff;
  logic [WIDTH-1:0] next_count;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic [WIDTH-1:0] load_clamped;

`ifdef UDC_STEP_EN
  logic [SW-1:0] step_w;
  assign step_w = {1'b0, step};
  assign s_eff  = (step_w > RNG_S) ? RNG_S : step_w;
`else
  assign s_eff = SW'(1);
`endif

  assign mode = sat_mode ? UDC_SAT : UDC_WRAP;

  assign load_clamped =
    WIDTH'(clamp(int'(load_val), MIN_VAL, MAX_VAL));

  // Count only on an enabled, unambiguous up or down request
  always_comb begin
    dir = UDC_HOLD;
    if (en && (up ^ down)) begin
      dir = up ? UDC_UP : UDC_DOWN;
    end
  end

  udc_next_calc #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL)
  ) u_calc (
    .count     (count),
    .dir       (dir),
    .s         (s_eff),
    .mode      (mode),
    .next_count(next_count),
    .ovf_nxt   (ovf_nxt),
    .unf_nxt   (unf_nxt)
  );

  // Count and pulse registers; load wins and clears the pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= WIDTH'(RST_VAL);
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= next_count;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end

  assign at_max = (count == WIDTH'(MAX_VAL));
  assign at_min = (count == WIDTH'(MIN_VAL));

endmodule
